coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front end that feeds the vending machine FSM's 2-bit `inp` coin code.
- Synchronises and debounces two raw coin-sensor lines (5 Rs and 10 Rs) and turns each clean insertion into one coin event.
- Buffers up to FIFO_DEPTH coins, then issues each one as a single-cycle code followed by at least one idle cycle.
- Rejects jammed (simultaneous) or overflowing coins.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before the debounced level changes; range 2..15.
- FIFO_DEPTH, 4: coin-code queue depth; power of 2, range 2..16.
- GAP_CYCLES, 1: minimum cycles of inp_code=00 between two issued coins; range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- coin5_raw  in  1  asynchronous 5 Rs sensor, high while coin is in the slot.
- coin10_raw  in  1  asynchronous 10 Rs sensor, high while coin is in the slot.
- accept_en  in  1  downstream ready; when low, no coin is issued and the queue holds.
- inp_code  out  2  to vending machine `inp`: 00 none, 01 5 Rs, 10 10 Rs; 11 is never driven.
- reject  out  1  one-cycle pulse: a coin was returned (jam or overflow).
- fifo_full  out  1  queue holds FIFO_DEPTH entries.
- total_rs  out  8  running deposited value in Rs (see Optional Feature).

Interface decision:
- One clock, clk.
- Reset is asynchronous and active-low, named reset_n.

Behaviour:
- Reset:
  - reset_n low immediately forces inp_code=00, reject=0, fifo_full=0 and total_rs=0.
  - It also empties the FIFO, clears synchroniser/debounce state (debounced levels 0) and puts the FSM in IDLE.
  - A reset mid-issue aborts the issue; the code is lost.
- Synchroniser: two flops per raw line, reset to 0.
- Debounce (per channel):
  - A counter runs while the synchronised level differs from the debounced level.
  - Any sample equal to the debounced level clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - A debounced 0->1 transition is a coin event, a one-cycle strobe.
- Event resolution, same cycle:
  - Both strobes together: jam. Reject pulses and nothing is queued.
  - Exactly one strobe: push 01 or 10.
- Latency: from a clean raw rising edge held stable, with FIFO empty, FSM in IDLE and accept_en=1, inp_code carries the code exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples the raw high.
- FIFO:
  - Push occurs on the event cycle.
  - If full with no pop in the same cycle: drop the coin and pulse reject the next cycle.
  - If full with a pop in the same cycle: accept the push.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
  - fifo_full is registered from next-state occupancy.
- Issue FSM:
  - IDLE: if FIFO non-empty and accept_en=1, pop and go to ISSUE.
  - ISSUE: inp_code = popped code for exactly 1 cycle; go to GAP.
  - GAP: inp_code=00 for GAP_CYCLES cycles (counter), then IDLE.
  - accept_en is sampled only in IDLE; deassertion during ISSUE or GAP does not truncate the pulse.
- inp_code is a registered output: 00 in every state except ISSUE.

Optional Feature:
- Macro: COIN_TOTAL_EN.
- Defined:
  - total_rs increments by 5 or 10 on the cycle a code is issued (ISSUE), not when it is queued.
  - It saturates at 255 and clears only on reset.
- Undefined: total_rs is tied to 0 and no adder or register is built.

Decomposition:
- Package coin_pkg:
  - Code constants COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10.
  - Issue FSM state enum {IDLE, ISSUE, GAP}.
  - Value constants VAL_5=8'd5, VAL_10=8'd10.
- Sub-module coin_debounce: synchroniser plus debounce counter plus rising-edge strobe, parameterised by DEBOUNCE_CYCLES, instantiated once per channel.
- FIFO and FSM stay in the top module.

Test Plan:
- Reset: hold reset_n=0 with coin10_raw=1, then release with the input held. Outputs stay 00/0/0 during reset. One 10 event is issued after DEBOUNCE_CYCLES+4 edges. total_rs=10 with COIN_TOTAL_EN.
- Bounce: coin5_raw toggles every cycle for 6 cycles, then holds high for 8 cycles. Exactly one inp_code=01 pulse of 1-cycle width; no reject.
- Sequence and spacing: 5, 10, 5, 5, 10 inserted 20 cycles apart with accept_en=1. inp_code pulses 01, 10, 01, 01, 10, each separated by at least GAP_CYCLES zeros. total_rs=35.
- Backpressure and overflow: accept_en=0, insert 5 coins with DEPTH=4. fifo_full rises after the 4th coin; the 5th coin gives a reject pulse. After accept_en=1, exactly 4 codes drain in insertion order.
- Jam: both raw lines rise on the same edge and hold. A single reject pulse, no code queued, inp_code stays 00.
- Reset mid-issue: assert reset_n during ISSUE with 3 entries queued. inp_code drops to 00 immediately; no codes are issued after release.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared constants and types for the coin acceptor front end.
//   Coin codes as driven on the vending machine `inp` bus.
//   Deposit values in Rs for the running total.
//   Issue FSM state encoding.
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } issue_state_e;

endpackage

// File: rtl/coin_debounce.sv
// Single-channel coin sensor conditioner: two-flop synchroniser, debounce counter and a
// registered one-cycle strobe on each debounced 0->1 transition.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset (clears sync, counter and level)
//   raw      asynchronous sensor line
//   rise     one-cycle strobe: debounced level just went 0->1 (a coin event)
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic rise
);

  localparam logic [3:0] CntMax = 4'(DEBOUNCE_CYCLES);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic       rise_q, rise_d;
  logic [3:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised sample disagrees with the
  // debounced level; any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q + 4'd1 == CntMax) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end for the vending machine FSM.
// Debounces the 5 Rs and 10 Rs sensor lines, queues coin events in a small FIFO and
// issues each as a single-cycle code on inp_code followed by at least GAP_CYCLES idle
// cycles. Simultaneous events (jam) and pushes into a full queue are rejected.
// Optional feature macro: COIN_TOTAL_EN (running deposited total on total_rs).
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   coin5_raw   asynchronous 5 Rs sensor
//   coin10_raw  asynchronous 10 Rs sensor
//   accept_en   downstream ready, sampled only in IDLE
//   inp_code    registered coin code: 00 none, 01 5 Rs, 10 10 Rs
//   reject      one-cycle pulse when a coin is returned (jam or overflow)
//   fifo_full   queue holds FIFO_DEPTH entries
//   total_rs    running deposited value (0 unless COIN_TOTAL_EN)
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       accept_en,
  output logic [1:0] inp_code,
  output logic       reject,
  output logic       fifo_full,
  output logic [7:0] total_rs
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);
  localparam logic [2:0] GapLast = 3'(GAP_CYCLES - 1);

  logic ev5, ev10;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db5 (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (coin5_raw),
    .rise    (ev5)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db10 (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (coin10_raw),
    .rise    (ev10)
  );

  // Event resolution and FIFO control
  logic            jam, push_req, push, pop, overflow;
  logic [1:0]      push_code;
  logic [1:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, reject_q;

  issue_state_e    state_q, state_d;
  logic [2:0]      gap_q, gap_d;
  logic [1:0]      code_q, code_d;

  assign jam       = ev5 & ev10;
  assign push_req  = ev5 ^ ev10;
  assign push_code = ev5 ? COIN_5 : COIN_10;
  assign pop       = (state_q == IDLE) && (count_q != '0) && accept_en;
  // A full queue still accepts a push when an entry leaves in the same cycle.
  assign push      = push_req && ((count_q != DepthC) || pop);
  assign overflow  = push_req && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_code;
    end
  end

  // Issue FSM
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    code_d  = COIN_NONE;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          code_d  = mem[rd_ptr_q];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == GapLast) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      reject_q <= 1'b0;
      state_q  <= IDLE;
      gap_q    <= '0;
      code_q   <= COIN_NONE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DepthC);
      reject_q <= jam | overflow;
      state_q  <= state_d;
      gap_q    <= gap_d;
      code_q   <= code_d;
    end
  end

  assign inp_code  = code_q;
  assign reject    = reject_q;
  assign fifo_full = full_q;

`ifdef COIN_TOTAL_EN
  logic [7:0] total_q;
  logic [7:0] add_val;
  logic [8:0] sum;

  always_comb begin
    add_val = 8'd0;
    if (code_q == COIN_10) begin
      add_val = VAL_10;
    end else if (code_q == COIN_5) begin
      add_val = VAL_5;
    end
    sum = {1'b0, total_q} + {1'b0, add_val};
  end

  // Counted when the code is on the bus, not when it was queued; saturates at 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total_q <= 8'd0;
    end else if (state_q == ISSUE) begin
      total_q <= sum[8] ? 8'hFF : sum[7:0];
    end
  end

  assign total_rs = total_q;
`else
  assign total_rs = 8'd0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4,
// GAP_CYCLES=1). Inputs change and outputs are sampled on the falling clock edge.
module tb_coin_acceptor;

  localparam int DB  = 4;
  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       coin5_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic       accept_en = 1'b1;
  logic [1:0] inp_code;
  logic       reject;
  logic       fifo_full;
  logic [7:0] total_rs;

  int n_total = 0;
  int n_pass  = 0;

  // Monitor state
  int   code_log [$];
  int   rej_cnt = 0;
  int   viol    = 0;
  bit   prev_nz = 1'b0;
  int   zeros   = 100;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (DB),
    .FIFO_DEPTH      (4),
    .GAP_CYCLES      (GAP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .accept_en  (accept_en),
    .inp_code   (inp_code),
    .reject     (reject),
    .fifo_full  (fifo_full),
    .total_rs   (total_rs)
  );

  always #5 clk = ~clk;

  // Logs every issued code and flags wide pulses, short gaps and the illegal code 11.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_nz = 1'b0;
      zeros   = 100;
    end else begin
      if (inp_code != 2'b00) begin
        code_log.push_back(int'(inp_code));
        if (prev_nz) viol++;
        if (zeros < GAP) viol++;
        if (inp_code == 2'b11) viol++;
        prev_nz = 1'b1;
        zeros   = 0;
      end else begin
        prev_nz = 1'b0;
        if (zeros < 100) zeros++;
      end
      if (reject) rej_cnt++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // c: 01 = 5 Rs, 10 = 10 Rs, 11 = both lines (jam)
  task automatic insert(input logic [1:0] c, input int hold, input int low);
    coin5_raw  = c[0];
    coin10_raw = c[1];
    step(hold);
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    step(low);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  int base;
  int rej_base;
  int exp_seq [5];
  int exp_bp [4];
  int tot_exp;
  int budget;

  initial begin
    // Reset held with the 10 Rs line already high
    coin10_raw = 1'b1;
    step(3);
    check("rst_inp_code", int'(inp_code), 0);
    check("rst_reject", int'(reject), 0);
    check("rst_fifo_full", int'(fifo_full), 0);
    check("rst_total", int'(total_rs), 0);
    base = code_log.size();
    reset_n = 1'b1;
    step(DB + 3);
    check("lat_before", int'(inp_code), 0);
    step(1);
    check("lat_code10", int'(inp_code), 2);
    step(1);
`ifdef COIN_TOTAL_EN
    tot_exp = 10;
`else
    tot_exp = 0;
`endif
    check("rst_total10", int'(total_rs), tot_exp);
    coin10_raw = 1'b0;
    step(20);
    check("rst_one_event", code_log.size() - base, 1);

    // Bounce then clean hold on the 5 Rs line
    base = code_log.size();
    rej_base = rej_cnt;
    for (int i = 0; i < 6; i++) begin
      coin5_raw = ((i % 2) == 0);
      step(1);
    end
    coin5_raw = 1'b1;
    step(8);
    coin5_raw = 1'b0;
    step(25);
    check("bounce_count", code_log.size() - base, 1);
    if (code_log.size() > base) check("bounce_code", code_log[base], 1);
    check("bounce_noreject", rej_cnt - rej_base, 0);

    // Sequence 5,10,5,5,10 from a fresh reset
    do_reset();
    check("seq_total_clr", int'(total_rs), 0);
    exp_seq = '{1, 2, 1, 1, 2};
    base = code_log.size();
    for (int i = 0; i < 5; i++) begin
      insert(2'(exp_seq[i]), 8, 12);
    end
    step(10);
    check("seq_count", code_log.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (code_log.size() > base + i) check($sformatf("seq_code%0d", i), code_log[base + i],
                                            exp_seq[i]);
    end
`ifdef COIN_TOTAL_EN
    tot_exp = 35;
`else
    tot_exp = 0;
`endif
    check("seq_total", int'(total_rs), tot_exp);

    // Backpressure and overflow
    accept_en = 1'b0;
    exp_bp = '{1, 2, 2, 1};
    base = code_log.size();
    rej_base = rej_cnt;
    for (int i = 0; i < 3; i++) insert(2'(exp_bp[i]), 8, 8);
    check("bp_not_full3", int'(fifo_full), 0);
    insert(2'(exp_bp[3]), 8, 8);
    check("bp_full4", int'(fifo_full), 1);
    check("bp_no_rej4", rej_cnt - rej_base, 0);
    insert(2'b01, 8, 8);
    check("bp_rej5", rej_cnt - rej_base, 1);
    check("bp_held", code_log.size() - base, 0);
    accept_en = 1'b1;
    step(30);
    check("bp_drain_count", code_log.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (code_log.size() > base + i) check($sformatf("bp_code%0d", i), code_log[base + i],
                                            exp_bp[i]);
    end
    check("bp_not_full_end", int'(fifo_full), 0);

    // Jam: both lines rise together
    base = code_log.size();
    rej_base = rej_cnt;
    insert(2'b11, 10, 20);
    check("jam_reject", rej_cnt - rej_base, 1);
    check("jam_no_code", code_log.size() - base, 0);

    // Reset during ISSUE with three entries still queued
    accept_en = 1'b0;
    insert(2'b01, 8, 8);
    insert(2'b01, 8, 8);
    insert(2'b10, 8, 8);
    insert(2'b10, 8, 8);
    accept_en = 1'b1;
    budget = 0;
    while (inp_code == 2'b00 && budget < 20) begin
      step(1);
      budget++;
    end
    check("mid_issue_seen", int'(inp_code), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_code", int'(inp_code), 0);
    check("mid_rst_full", int'(fifo_full), 0);
    step(2);
    reset_n = 1'b1;
    base = code_log.size();
    step(30);
    check("mid_rst_nocodes", code_log.size() - base, 0);
    check("mid_rst_total", int'(total_rs), 0);

    check("pulse_rules", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
